// File: rtl/adder_pkg.sv
// Shared constants and decode helpers for the convolution adder tree.
package adder_pkg;

    localparam int unsigned LANES = 36;
    localparam int unsigned CH    = 8;
    localparam int unsigned TAPS  = 16;
    localparam int unsigned PW    = 16;
    localparam int unsigned SW    = 24;
    localparam int unsigned GRID  = 6;

    localparam logic [3:0] WS_3 = 4'd0;
    localparam logic [3:0] WS_5 = 4'd1;
    localparam logic [3:0] WS_7 = 4'd2;

    function automatic logic [2:0] nrounds(input logic [3:0] wsize);
        case (wsize)
            WS_5:    return 3'd2;
            WS_7:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [TAPS-1:0] tap_mask(input logic [3:0] wsize, input logic [2:0] wround);
        case (wsize)
            WS_5:    return (wround == 3'd0) ? 16'hFFFF : 16'h01FF;
            WS_7:    return (wround < 3'd3) ? 16'hFFFF : 16'h0001;
            default: return 16'h01FF;
        endcase
    endfunction

    // Lanes surviving stride-2 decimation: even row and even column.
    function automatic logic [LANES-1:0] stride_keep();
        logic [LANES-1:0] keep;
        for (int k = 0; k < LANES; k++) begin
            keep[k] = ((k / GRID) % 2 == 0) && ((k % GRID) % 2 == 0);
        end
        return keep;
    endfunction

endpackage

// File: rtl/adder_lane.sv
// One output position: masked reduction of 128 signed products, registered (stage 1).
module adder_lane
    import adder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [TAPS-1:0]       mask,
    input  logic [CH*TAPS*PW-1:0] products,
    output logic [SW-1:0]         sum
);

    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < CH * TAPS; p++) begin
            if (mask[p % TAPS]) begin
                sum_d = sum_d + {{(SW - PW){products[p*PW + PW - 1]}}, products[p*PW +: PW]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/adder_tree.sv
// Convolution reduction stage: per-lane round sums, multi-round accumulation,
// stride-2 lane zeroing and the registered Psum output.
module adder_tree
    import adder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   wsize,
    input  logic                         stride,
    input  logic [2:0]                   wround,
    input  logic [LANES*CH*TAPS*PW-1:0]  MUL_results,
    input  logic                         MUL_DATA_valid,
    output logic [LANES*SW-1:0]          Psum,
    output logic                         Psum_valid
);

    localparam logic [LANES-1:0] KEEP = stride_keep();

    logic [TAPS-1:0] mask;
    logic            first;
    logic            last;

    assign mask  = tap_mask(wsize, wround);
    assign first = (wround == 3'd0);
    assign last  = (wround == nrounds(wsize) - 3'd1);

    logic          s1_valid_q, s1_first_q, s1_last_q, s1_stride_q;
    logic          done_q, done_stride_q;
    logic [SW-1:0] lane_sum [LANES];
    logic [SW-1:0] acc_q    [LANES];
    logic [LANES*SW-1:0] psum_q;
    logic                psum_valid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        adder_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (MUL_DATA_valid),
            .mask     (mask),
            .products (MUL_results[k*CH*TAPS*PW +: CH*TAPS*PW]),
            .sum      (lane_sum[k])
        );
    end

    // Accumulator settles one edge after stage 1; Psum is copied out on the following edge,
    // so a new kernel can load the accumulator while the finished one is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_stride_q   <= 1'b0;
            done_q        <= 1'b0;
            done_stride_q <= 1'b0;
            psum_q        <= '0;
            psum_valid_q  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            s1_valid_q    <= MUL_DATA_valid;
            s1_first_q    <= first;
            s1_last_q     <= last;
            s1_stride_q   <= stride;
            done_q        <= s1_valid_q & s1_last_q;
            done_stride_q <= s1_stride_q;
            psum_valid_q  <= done_q;
            if (s1_valid_q) begin
                for (int k = 0; k < LANES; k++) begin
                    acc_q[k] <= s1_first_q ? lane_sum[k] : acc_q[k] + lane_sum[k];
                end
            end
            if (done_q) begin
                for (int k = 0; k < LANES; k++) begin
                    psum_q[k*SW +: SW] <= (done_stride_q && !KEEP[k]) ? '0 : acc_q[k];
                end
            end
        end
    end

    assign Psum       = psum_q;
    assign Psum_valid = psum_valid_q;

endmodule

// File: tb/tb_adder_tree.sv
// Self-checking bench for adder_tree: scoreboard of expected Psum vectors and output edges.
module tb_adder_tree;
    import adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic [3:0]                  wsize;
    logic                        stride;
    logic [2:0]                  wround;
    logic [LANES*CH*TAPS*PW-1:0] mul_results;
    logic                        mul_valid;
    logic [LANES*SW-1:0]         psum;
    logic                        psum_valid;

    adder_tree dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wsize          (wsize),
        .stride         (stride),
        .wround         (wround),
        .MUL_results    (mul_results),
        .MUL_DATA_valid (mul_valid),
        .Psum           (psum),
        .Psum_valid     (psum_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [LANES*SW-1:0] exp_q[$];
    int                  exp_cyc_q[$];
    logic [LANES*SW-1:0] got_q[$];
    int                  got_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (psum_valid === 1'b1) begin
            got_q.push_back(psum);
            got_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [LANES*SW-1:0] make_exp(input int v, input bit st);
        int keep_list[9] = '{0, 2, 4, 12, 14, 16, 24, 26, 28};
        logic [SW-1:0] val;
        logic [LANES*SW-1:0] r;
        val = v[SW-1:0];
        r = '0;
        if (!st) begin
            for (int k = 0; k < 36; k++) r[k*24 +: 24] = val;
        end else begin
            for (int i = 0; i < 9; i++) r[keep_list[i]*24 +: 24] = val;
        end
        return r;
    endfunction

    task automatic set_products(input logic [15:0] lo, input logic [15:0] hi, input int split);
        for (int k = 0; k < 36; k++)
            for (int c = 0; c < 8; c++)
                for (int t = 0; t < 16; t++)
                    mul_results[k*2048 + (c*16 + t)*16 +: 16] = (t < split) ? lo : hi;
    endtask

    // Presents one round; returns the cycle stamp of the edge that sampled it.
    task automatic send(input logic [3:0] ws, input logic [2:0] wr, input bit st, output int n);
        wsize = ws;
        wround = wr;
        stride = st;
        mul_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        mul_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wsize = WS_3;
        stride = 1'b0;
        wround = 3'd0;
        mul_valid = 1'b0;
        mul_results = '0;
        idle(3);
        checks++;
        if (psum !== '0) begin
            errors++;
            $display("FAIL reset_psum: got %h expected 0", psum);
        end
        checks++;
        if (psum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", psum_valid);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_3x3();
        int n;
        logic [LANES*SW-1:0] e;
        int ec;
        flush();
        set_products(16'd1, 16'd1, 16);
        send(WS_3, 3'd0, 1'b0, n);
        exp_q.push_back(make_exp(72, 1'b0));
        exp_cyc_q.push_back(n + 2);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL 3x3_missing: got no pulse expected %h", e);
            end else begin
                checks++;
                if (got_cyc_q[0] != ec) begin
                    errors++;
                    $display("FAIL 3x3_latency: got cycle %0d expected %0d", got_cyc_q[0], ec);
                end
                if (got_q[0] !== e) begin
                    errors++;
                    $display("FAIL 3x3_value: got %h expected %h", got_q[0], e);
                end
                void'(got_q.pop_front());
                void'(got_cyc_q.pop_front());
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL 3x3_extra_pulse: got %0d extra expected 0", got_q.size());
        end
    endtask

    task automatic test_5x5();
        int n;
        logic [LANES*SW-1:0] e;
        int ec;
        flush();
        set_products(16'd1, 16'd1, 16);
        send(WS_5, 3'd0, 1'b0, n);
        send(WS_5, 3'd1, 1'b0, n);
        exp_q.push_back(make_exp(200, 1'b0));
        exp_cyc_q.push_back(n + 2);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL 5x5_pulse_count: got %0d expected 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (got_q[0] !== e || got_cyc_q[0] != ec) begin
                errors++;
                $display("FAIL 5x5_result: got %h @%0d expected %h @%0d",
                         got_q[0], got_cyc_q[0], e, ec);
            end
            void'(got_q.pop_front());
            void'(got_cyc_q.pop_front());
        end
    endtask

    task automatic test_7x7();
        int n;
        logic [LANES*SW-1:0] e;
        int ec;
        flush();
        set_products(16'hFFFF, 16'hFFFF, 16);
        for (int r = 0; r < 4; r++) send(WS_7, 3'(r), 1'b0, n);
        exp_q.push_back(make_exp(-392, 1'b0));
        exp_cyc_q.push_back(n + 2);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL 7x7_pulse_count: got %0d expected 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (got_q[0] !== e || got_cyc_q[0] != ec) begin
                errors++;
                $display("FAIL 7x7_result: got %h @%0d expected %h @%0d",
                         got_q[0], got_cyc_q[0], e, ec);
            end
            void'(got_q.pop_front());
            void'(got_cyc_q.pop_front());
        end
    endtask

    task automatic test_mask();
        int n;
        logic [LANES*SW-1:0] e;
        flush();
        set_products(16'd2, 16'h7FFF, 9);
        send(WS_3, 3'd0, 1'b0, n);
        e = make_exp(144, 1'b0);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL mask_pulse_count: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e || got_cyc_q[0] != n + 2) begin
                errors++;
                $display("FAIL mask_result: got %h @%0d expected %h @%0d",
                         got_q[0], got_cyc_q[0], e, n + 2);
            end
        end
    endtask

    task automatic test_stride();
        int n;
        logic [LANES*SW-1:0] e;
        flush();
        set_products(16'd1, 16'd1, 16);
        send(WS_3, 3'd0, 1'b1, n);
        e = make_exp(72, 1'b1);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL stride_pulse_count: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                errors++;
                $display("FAIL stride_value: got %h expected %h", got_q[0], e);
            end
        end
        stride = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        flush();
        set_products(16'd5, 16'd5, 16);
        send(WS_7, 3'd0, 1'b0, n);
        send(WS_7, 3'd1, 1'b0, n);
        rst_n = 1'b0;
        #1;
        checks++;
        if (psum !== '0) begin
            errors++;
            $display("FAIL mid_reset_psum: got %h expected 0", psum);
        end
        checks++;
        if (psum_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid: got %b expected 0", psum_valid);
        end
        idle(1);
        rst_n = 1'b1;
        idle(8);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pulse: got %0d pulses expected 0", got_q.size());
        end
    endtask

    task automatic test_bubble();
        int n;
        logic [LANES*SW-1:0] e;
        flush();
        set_products(16'd1, 16'd1, 16);
        send(WS_5, 3'd0, 1'b0, n);
        set_products(16'h1234, 16'h4321, 5);
        wround = 3'd1;
        idle(1);
        set_products(16'd1, 16'd1, 16);
        send(WS_5, 3'd1, 1'b0, n);
        e = make_exp(200, 1'b0);
        idle(8);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL bubble_pulse_count: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e || got_cyc_q[0] != n + 2) begin
                errors++;
                $display("FAIL bubble_result: got %h @%0d expected %h @%0d",
                         got_q[0], got_cyc_q[0], e, n + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [LANES*SW-1:0] e;
        int ec;
        flush();
        set_products(16'd1, 16'd1, 16);
        send(WS_3, 3'd0, 1'b0, n);
        exp_q.push_back(make_exp(72, 1'b0));
        exp_cyc_q.push_back(n + 2);
        set_products(16'd3, 16'd3, 16);
        send(WS_3, 3'd0, 1'b0, n);
        exp_q.push_back(make_exp(216, 1'b0));
        exp_cyc_q.push_back(n + 2);
        set_products(16'hFFFF, 16'hFFFF, 16);
        send(WS_5, 3'd0, 1'b0, n);
        send(WS_5, 3'd1, 1'b0, n);
        exp_q.push_back(make_exp(-200, 1'b0));
        exp_cyc_q.push_back(n + 2);
        set_products(16'd2, 16'd2, 16);
        send(WS_3, 3'd0, 1'b0, n);
        exp_q.push_back(make_exp(144, 1'b0));
        exp_cyc_q.push_back(n + 2);
        idle(10);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d expected 4", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (got_q[0] !== e || got_cyc_q[0] != ec) begin
                errors++;
                $display("FAIL b2b_result: got %h @%0d expected %h @%0d",
                         got_q[0], got_cyc_q[0], e, ec);
            end
            void'(got_q.pop_front());
            void'(got_cyc_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_3x3();
        test_5x5();
        test_7x7();
        test_mask();
        test_stride();
        test_7x7();
        test_reset_mid();
        test_bubble();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
